// File: rtl/seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
// States, opcode classes and error codes.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_IMEM    = 2'b10,
    ERR_DMEM    = 2'b11
  } err_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic is_legal(
    input logic [6:0] op
  );
    case (op)
      OPC_OP, OPC_IMM, OPC_LOAD,
      OPC_STORE, OPC_BRANCH, OPC_JAL,
      OPC_JALR, OPC_LUI, OPC_AUIPC:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction/data memory handshake bundle.
// The sequencer drives requests; memories answer with ready.
interface core_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic dmem_re;
  logic dmem_we;

  modport master (
    output imem_req, dmem_req,
    output dmem_re, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req,
    input  dmem_re, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/wait_timer.sv
// Consecutive wait-cycle counter shared by FETCH and MEM.
// expired flags the cycle that would be the TIMEOUT-th wait.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = count_en
    && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer with handshaked
// memories, halt, error trapping and retire counter.
module core_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  core_sequencer_if.master mem,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  input  logic             halt_req,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t st, st_nx;
  err_t   err_q, err_nx;
  logic   waiting;
  logic   expired;

  assign waiting =
    (st == S_FETCH && !mem.imem_ready) ||
    (st == S_MEM && !mem.dmem_ready);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (st_nx != st),
    .count_en (waiting),
    .expired  (expired)
  );

  always_comb begin
    st_nx  = st;
    err_nx = err_q;
    unique case (st)
      S_IDLE:
        st_nx = halt_req ? S_HALT : S_FETCH;
      S_FETCH: begin
        if (mem.imem_ready) begin
          st_nx = S_DECODE;
        end else if (expired) begin
          st_nx  = S_ERROR;
          err_nx = ERR_IMEM;
        end
      end
      S_DECODE: begin
        if (opcode == OPC_SYSTEM) begin
          st_nx = S_HALT;
        end else if (is_legal(opcode)) begin
          st_nx = S_EXEC;
        end else begin
          st_nx  = S_ERROR;
          err_nx = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (opcode == OPC_LOAD ||
            opcode == OPC_STORE) begin
          st_nx = S_MEM;
        end else begin
          st_nx = S_WB;
        end
      end
      S_MEM: begin
        if (mem.dmem_ready) begin
          st_nx = S_WB;
        end else if (expired) begin
          st_nx  = S_ERROR;
          err_nx = ERR_DMEM;
        end
      end
      S_WB:
        st_nx = halt_req ? S_HALT : S_FETCH;
      S_HALT:
        if (!halt_req) st_nx = S_FETCH;
      S_ERROR:
        st_nx = S_ERROR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st      <= S_IDLE;
      err_q   <= ERR_NONE;
      retired <= '0;
    end else begin
      st    <= st_nx;
      err_q <= err_nx;
      if (st == S_WB) begin
        retired <= retired + 1'b1;
      end
    end
  end

  // Enables decode straight from state so reset forces them low.
  assign mem.imem_req = (st == S_FETCH);
  assign mem.dmem_req = (st == S_MEM);
  assign mem.dmem_re  = (st == S_MEM) && mem_read;
  assign mem.dmem_we  = (st == S_MEM) && mem_write;
  assign ir_we    = (st == S_FETCH) && mem.imem_ready;
  assign pc_we    = (st == S_WB);
  assign rf_we    = (st == S_WB) && reg_write;
  assign halted   = (st == S_HALT);
  assign error    = (st == S_ERROR);
  assign err_code = err_q;
  assign state    = st;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-cycle expected
// state/enable vectors are queued and checked at negedge.
module tb_core_sequencer;
  import seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic       reg_write = 1'b0;
  logic       halt_req = 1'b0;
  logic       ir_we, pc_we, rf_we;
  logic       halted, error;
  logic [1:0] err_code;
  logic [2:0] state;
  logic [3:0] retired;

  core_sequencer_if bus();

  core_sequencer #(
    .TIMEOUT (15),
    .CNT_W   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .mem       (bus),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .halt_req  (halt_req),
    .halted    (halted),
    .error     (error),
    .err_code  (err_code),
    .state     (state),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  // {imem_req, ir_we, dmem_req, dmem_re, dmem_we, rf_we, pc_we}
  localparam logic [6:0] EN_0  = 7'b0000000;
  localparam logic [6:0] EN_F  = 7'b1000000;
  localparam logic [6:0] EN_FR = 7'b1100000;
  localparam logic [6:0] EN_LD = 7'b0011000;
  localparam logic [6:0] EN_ST = 7'b0010100;
  localparam logic [6:0] EN_WB = 7'b0000011;
  localparam logic [6:0] EN_PC = 7'b0000001;

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [11:0] obs = {
    state, bus.imem_req, ir_we, bus.dmem_req,
    bus.dmem_re, bus.dmem_we, rf_we, pc_we,
    halted, error
  };

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.tag, 32'(obs), 32'(e.v));
    end
  end

  // Called at posedge+1 with this cycle's inputs applied.
  task automatic tick(
    input string      tag,
    input state_t     st,
    input logic [6:0] en
  );
    exp_t e;
    e.tag = tag;
    e.v   = {st, en, st == S_HALT, st == S_ERROR};
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_out"}, 32'(obs), 32'd0);
    chk({tag, "_ret"}, 32'(retired), 32'd0);
    chk({tag, "_err"}, 32'(err_code), 32'd0);
    @(posedge clock);
    #1;
    chk({tag, "_hold"}, 32'(obs), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_out", 32'(obs), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    reset = 1'b1;

    // ALU op, zero-wait fetch
    bus.imem_ready = 1'b1;
    opcode = OPC_OP;
    reg_write = 1'b1;
    tick("alu_idle", S_IDLE, EN_0);
    tick("alu_fetch", S_FETCH, EN_FR);
    tick("alu_dec", S_DECODE, EN_0);
    tick("alu_exec", S_EXEC, EN_0);
    tick("alu_wb", S_WB, EN_WB);
    chk("alu_ret", 32'(retired), 32'd1);

    // Load with three dmem wait cycles
    opcode = OPC_LOAD;
    mem_read = 1'b1;
    tick("ld_fetch", S_FETCH, EN_FR);
    tick("ld_dec", S_DECODE, EN_0);
    tick("ld_exec", S_EXEC, EN_0);
    for (int i = 0; i < 3; i++)
      tick("ld_wait", S_MEM, EN_LD);
    bus.dmem_ready = 1'b1;
    tick("ld_mem", S_MEM, EN_LD);
    bus.dmem_ready = 1'b0;
    tick("ld_wb", S_WB, EN_WB);
    chk("ld_ret", 32'(retired), 32'd2);

    // Store with two imem wait cycles
    opcode = OPC_STORE;
    mem_read = 1'b0;
    mem_write = 1'b1;
    reg_write = 1'b0;
    bus.imem_ready = 1'b0;
    tick("st_fw0", S_FETCH, EN_F);
    tick("st_fw1", S_FETCH, EN_F);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    tick("st_fetch", S_FETCH, EN_FR);
    tick("st_dec", S_DECODE, EN_0);
    tick("st_exec", S_EXEC, EN_0);
    tick("st_mem", S_MEM, EN_ST);
    tick("st_wb", S_WB, EN_PC);
    chk("st_ret", 32'(retired), 32'd3);

    // Halt raised mid-EXEC
    opcode = OPC_IMM;
    mem_write = 1'b0;
    reg_write = 1'b1;
    bus.dmem_ready = 1'b0;
    tick("h_fetch", S_FETCH, EN_FR);
    tick("h_dec", S_DECODE, EN_0);
    halt_req = 1'b1;
    tick("h_exec", S_EXEC, EN_0);
    tick("h_wb", S_WB, EN_WB);
    tick("h_halt0", S_HALT, EN_0);
    tick("h_halt1", S_HALT, EN_0);
    chk("h_ret", 32'(retired), 32'd4);
    halt_req = 1'b0;
    tick("h_halt2", S_HALT, EN_0);

    // SYSTEM opcode halts without retiring
    opcode = OPC_SYSTEM;
    tick("sys_fetch", S_FETCH, EN_FR);
    tick("sys_dec", S_DECODE, EN_0);
    tick("sys_halt", S_HALT, EN_0);
    chk("sys_ret", 32'(retired), 32'd4);

    // Retire 13 more: 4-bit counter wraps through 0
    opcode = OPC_LUI;
    for (int i = 0; i < 13; i++) begin
      tick("lp_fetch", S_FETCH, EN_FR);
      tick("lp_dec", S_DECODE, EN_0);
      tick("lp_exec", S_EXEC, EN_0);
      tick("lp_wb", S_WB, EN_WB);
      chk("lp_ret", 32'(retired),
          32'((4 + i + 1) % 16));
    end

    // Reset asserted while a store waits in MEM
    opcode = OPC_STORE;
    mem_write = 1'b1;
    reg_write = 1'b0;
    tick("mr_fetch", S_FETCH, EN_FR);
    tick("mr_dec", S_DECODE, EN_0);
    tick("mr_exec", S_EXEC, EN_0);
    tick("mr_mem", S_MEM, EN_ST);
    pulse_reset("mr_rst");

    // Ready on the 15th fetch cycle still wins
    opcode = OPC_OP;
    mem_write = 1'b0;
    reg_write = 1'b1;
    bus.imem_ready = 1'b0;
    tick("b_idle", S_IDLE, EN_0);
    for (int i = 0; i < 14; i++)
      tick("b_fwait", S_FETCH, EN_F);
    bus.imem_ready = 1'b1;
    tick("b_fetch", S_FETCH, EN_FR);
    tick("b_dec", S_DECODE, EN_0);
    tick("b_exec", S_EXEC, EN_0);
    tick("b_wb", S_WB, EN_WB);
    chk("b_ret", 32'(retired), 32'd1);

    // Illegal opcode traps and holds
    opcode = 7'h7F;
    tick("il_fetch", S_FETCH, EN_FR);
    tick("il_dec", S_DECODE, EN_0);
    chk("il_code", 32'(err_code), 32'd1);
    halt_req = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      tick("il_hold", S_ERROR, EN_0);
    halt_req = 1'b0;
    bus.dmem_ready = 1'b0;
    chk("il_code2", 32'(err_code), 32'd1);
    pulse_reset("il_rst");

    // Instruction memory never answers
    opcode = OPC_OP;
    bus.imem_ready = 1'b0;
    tick("it_idle", S_IDLE, EN_0);
    for (int i = 0; i < 15; i++)
      tick("it_fwait", S_FETCH, EN_F);
    tick("it_err", S_ERROR, EN_0);
    chk("it_code", 32'(err_code), 32'd2);
    bus.imem_ready = 1'b1;
    tick("it_hold", S_ERROR, EN_0);
    chk("it_code2", 32'(err_code), 32'd2);
    pulse_reset("it_rst");

    // Data memory never answers
    opcode = OPC_LOAD;
    mem_read = 1'b1;
    tick("dt_idle", S_IDLE, EN_0);
    tick("dt_fetch", S_FETCH, EN_FR);
    tick("dt_dec", S_DECODE, EN_0);
    tick("dt_exec", S_EXEC, EN_0);
    for (int i = 0; i < 15; i++)
      tick("dt_wait", S_MEM, EN_LD);
    tick("dt_err", S_ERROR, EN_0);
    chk("dt_code", 32'(err_code), 32'd3);
    chk("dt_ret", 32'(retired), 32'd0);
    pulse_reset("dt_rst");

    // Halt request seen in IDLE
    mem_read = 1'b0;
    halt_req = 1'b1;
    tick("ih_idle", S_IDLE, EN_0);
    tick("ih_halt0", S_HALT, EN_0);
    halt_req = 1'b0;
    tick("ih_halt1", S_HALT, EN_0);
    tick("ih_fetch", S_FETCH, EN_FR);

    @(negedge clock);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and issues the per-phase write enables: PC, instruction register, register file and data memory. It replaces the free-running PC update with a handshaked one, so instruction and data memories can take wait states. It also provides halt, illegal-opcode and memory-timeout handling, plus a retired-instruction counter.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum number of wait cycles on a memory handshake before the block enters ERROR.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clock` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 7: instruction bits [6:0], taken from the instruction register.
- `mem_read` in 1: from the control unit.
- `mem_write` in 1: from the control unit.
- `reg_write` in 1: from the control unit.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: instruction word is valid this cycle.
- `dmem_req` out 1: data access request.
- `dmem_ready` in 1: data access completes this cycle.
- `dmem_re` out 1: data memory read enable.
- `dmem_we` out 1: data memory write enable.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC register load from PCnext.
- `rf_we` out 1: register file write enable.
- `halt_req` in 1: level request to stop at the next instruction boundary.
- `halted` out 1: high while in HALT.
- `error` out 1: high while in ERROR (sticky).
- `err_code` out 2: 00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- `state` out 3: current state encoding.
- `retired` out CNT_W: count of completed instructions.

## Operation
State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.

Transitions:
- **IDLE** → HALT if `halt_req`, else → FETCH.
- **FETCH**
  - `imem_req`=1 throughout.
  - When `imem_ready`: `ir_we`=1 that same cycle, → DECODE.
  - Wait counter increments on every cycle without ready. If the counter reaches TIMEOUT: → ERROR with code 10.
- **DECODE** classifies `opcode`:
  - Legal set: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 → EXEC.
  - 1110011 (system) → HALT. The instruction is not retired and PC is not advanced.
  - Any other value → ERROR with code 01.
- **EXEC** (one cycle)
  - Opcode 0000011 or 0100011 → MEM.
  - Otherwise → WB.
- **MEM**
  - `dmem_req`=1, `dmem_re`=`mem_read`, `dmem_we`=`mem_write`, all held until `dmem_ready`. Then → WB.
  - Timeout → ERROR with code 11. `dmem_we` deasserts on the transition.
- **WB** (one cycle)
  - `rf_we`=`reg_write`, `pc_we`=1.
  - `retired` increments and wraps from all-ones to 0.
  - → HALT if `halt_req`, else → FETCH.
- **HALT**
  - All enables 0, `halted`=1.
  - When `halt_req` is low: → FETCH.
- **ERROR**
  - All enables 0, `error`=1.
  - Leaves only on reset. `err_code` is held.

Rules:
- `halt_req` is sampled only in IDLE, WB and HALT. An instruction in flight always completes.
- The wait counter clears on every state change.
- `ir_we`, `pc_we`, `rf_we` and `dmem_we` are never high outside FETCH, WB and MEM respectively.
- Asserting reset mid-instruction aborts it:
  - No enable may glitch high during reset.
  - A partially completed MEM is not retried.

## Timing
- Reset values: state=IDLE, and every output is 0 (including `retired` and `err_code`).
- Enables are combinational from the state register and the ready inputs. There is no registered-output latency.
- Non-memory instruction with zero-wait fetch: 4 cycles (FETCH, DECODE, EXEC, WB).
- Load or store with zero-wait memory: 5 cycles.
- Each cycle of wait on `imem_ready` or `dmem_ready` adds exactly 1 cycle.
- Timeout: ERROR is entered on the edge after the TIMEOUT-th consecutive not-ready cycle. A ready arriving in that same cycle wins.
- `halted` rises 1 cycle after the WB in which `halt_req` was seen high.
- FETCH starts 1 cycle after `halt_req` falls.
- First FETCH is 1 cycle after reset deasserts (IDLE lasts one cycle).

## Structure
- Package `seq_pkg`:
  - State encoding constants.
  - RV32I opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM).
  - `err_code` values.
- One sub-module, `wait_timer`:
  - Inputs: `clear`, `count_en`.
  - Output: `expired` when the count reaches TIMEOUT.
  - Instantiated once and shared by FETCH and MEM.

## Test plan
- **Reset and ALU instruction:** release `reset`, `imem_ready`=1, `opcode`=0110011, `reg_write`=1 → states 0,1,2,3,5,1. `ir_we` is high in cycle 1, `rf_we` and `pc_we` are high in cycle 4, and `retired`=1.
- **Load with wait states:** `opcode`=0000011, `mem_read`=1, `dmem_ready` asserted after 3 cycles → MEM lasts 4 cycles, `dmem_re`=1 throughout, `dmem_we`=0, and the instruction takes 8 cycles in total.
- **Store:** `opcode`=0100011, `mem_write`=1, `reg_write`=0 → `dmem_we`=1 only in MEM, and `rf_we`=0 in WB.
- **Halt:**
  - `halt_req` raised mid-EXEC → WB completes, then `halted`=1. `retired` is unchanged while halted.
  - `halt_req` dropped → FETCH the next cycle.
  - `opcode`=1110011 → HALT with no retire.
- **Errors:**
  - `opcode`=1111111 → ERROR, `err_code`=01.
  - `imem_ready` held 0 with TIMEOUT=15 → ERROR after 15 FETCH cycles, `err_code`=10.
  - In both cases the state holds until reset.
- **Wrap and reset:** with `CNT_W`=4, retire 16 instructions → `retired` wraps to 0. Asserting `reset` during MEM → all outputs 0 at once and state=IDLE.
